// File: rtl/ram_dp_init.sv
// Dual-port data memory (A: read/write, B: read-only) with a hardware preload sweep after reset.
// Define RAM_PARITY_EN to store and check one even-parity bit per word.
module ram_dp_init #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1024,
    parameter int RDW_MODE     = 0,
    parameter int INIT_PATTERN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              busy,
    output logic              a_perr,
    output logic              b_perr
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
    logic              par_mem [DEPTH];
`endif

    logic              run;
    logic              a_in_range;
    logic              b_in_range;
    logic              a_rd_req;
    logic              a_wr_req;
    logic              b_rd_req;
    logic              b_collide;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] idx);
        if (INIT_PATTERN == 1)
            return DATA_W'(idx);
        else
            return '0;
    endfunction

    assign run        = (state == S_RUN);
    assign a_in_range = ({1'b0, a_addr} < DEPTH_EXT);
    assign b_in_range = ({1'b0, b_addr} < DEPTH_EXT);
    assign a_rd_req   = run && a_en && !a_we;
    assign a_wr_req   = run && a_en && a_we && a_in_range;
    assign b_rd_req   = run && b_en;
    assign b_collide  = a_wr_req && (a_addr == b_addr);

    // Single write port shared by the init sweep and port A stores.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_en   = 1'b0;
        wr_addr = a_addr;
        wr_data = a_wdata;
        if (state == S_INIT && rst_n) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = init_word(cnt);
        end else if (a_wr_req) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: the array has no reset; the init sweep gives it defined contents instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
`ifdef RAM_PARITY_EN
            par_mem[wr_addr] <= ^wr_data;
`endif
        end
    end

    // Init sequencer: one word per edge, busy drops on the edge that writes the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= S_INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == LAST_IDX) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= S_INIT;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Port A read register; rdata holds when there is no load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_rd_req;
            if (a_rd_req)
                a_rdata <= a_in_range ? mem[a_addr] : '0;
        end
    end

    // Port B read register; the array read returns pre-write data, so read-first needs no bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
        end else begin
            b_rvalid <= b_rd_req;
            if (b_rd_req) begin
                if (!b_in_range)
                    b_rdata <= '0;
                else if (RDW_MODE == 1 && b_collide)
                    b_rdata <= a_wdata;
                else
                    b_rdata <= mem[b_addr];
            end
        end
    end

`ifdef RAM_PARITY_EN
    // Recompute parity on read; forwarded write data is fresh and cannot mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_perr <= 1'b0;
            b_perr <= 1'b0;
        end else begin
            a_perr <= a_rd_req && a_in_range && ((^mem[a_addr]) != par_mem[a_addr]);
            b_perr <= b_rd_req && b_in_range && !(RDW_MODE == 1 && b_collide)
                      && ((^mem[b_addr]) != par_mem[b_addr]);
        end
    end
`else
    assign a_perr = 1'b0;
    assign b_perr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dp_init.sv
// Self-checking bench for ram_dp_init: randomized traffic against an array model of the memory.
// Define RAM_PARITY_EN to also exercise the parity fault detection.
module tb_ram_dp_init;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 1024;
    localparam int RDW_MODE = 0;

    logic              clk;
    logic              rst_n;
    logic              a_en, a_we, b_en;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              a_rvalid, b_rvalid, busy, a_perr, b_perr;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] last_a, last_b;

    ram_dp_init dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_en    (a_en),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .a_rvalid(a_rvalid),
        .b_en    (b_en),
        .b_addr  (b_addr),
        .b_rdata (b_rdata),
        .b_rvalid(b_rvalid),
        .busy    (busy),
        .a_perr  (a_perr),
        .b_perr  (b_perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] addr);
        if (int'(addr) < DEPTH)
            return model_mem[addr];
        return '0;
    endfunction

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++)
            model_mem[i] = DATA_W'(i);
    endtask

    // Drive one request cycle at the falling edge, then sample just after the rising edge.
    task automatic cycle(input logic ae, input logic awe, input logic [ADDR_W-1:0] aa,
                         input logic [DATA_W-1:0] awd, input logic be,
                         input logic [ADDR_W-1:0] ba);
        @(negedge clk);
        a_en = ae; a_we = awe; a_addr = aa; a_wdata = awd; b_en = be; b_addr = ba;
        @(posedge clk);
        #1;
    endtask

    // Release reset and count edges until busy drops; random requests are offered throughout.
    task automatic run_init(output int n_busy, output int stray_rvalid);
        n_busy       = -1;
        stray_rvalid = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 1; n <= 2000; n++) begin
            if (n == 5)
                cycle(1'b1, 1'b1, 10'h010, 16'hBEEF, 1'b1, 10'h010);
            else
                cycle(1'b1, 1'b0, ADDR_W'($urandom), '0, 1'b1, ADDR_W'($urandom));
            if (a_rvalid || b_rvalid)
                stray_rvalid++;
            if (!busy) begin
                n_busy = n;
                break;
            end
        end
        cycle(0, 0, '0, '0, 0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_en = 0; a_we = 0; a_addr = '0; a_wdata = '0; b_en = 0; b_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL reset_busy got=%b exp=1", busy);
        end
        tests_run++;
        if ({a_rvalid, b_rvalid, a_perr, b_perr} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=0000", {a_rvalid, b_rvalid, a_perr, b_perr});
        end
        tests_run++;
        if (a_rdata !== '0 || b_rdata !== '0) begin
            tests_failed++; $display("FAIL reset_rdata got=%h/%h exp=0000/0000", a_rdata, b_rdata);
        end
    endtask

    task automatic test_init();
        int n_busy, stray;
        run_init(n_busy, stray);
        model_init();
        tests_run++;
        if (n_busy != DEPTH) begin
            tests_failed++; $display("FAIL init_busy_cycles got=%0d exp=%0d", n_busy, DEPTH);
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++; $display("FAIL init_rvalid_during_busy got=%0d exp=0", stray);
        end
        cycle(1, 0, 10'h005, '0, 1, 10'h3FF);
        tests_run++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'h0005) begin
            tests_failed++; $display("FAIL first_a_read got=%b/%h exp=1/0005", a_rvalid, a_rdata);
        end
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 16'h03FF) begin
            tests_failed++; $display("FAIL first_b_read got=%b/%h exp=1/03ff", b_rvalid, b_rdata);
        end
        cycle(1, 0, 10'h010, '0, 0, '0);
        tests_run++;
        if (a_rdata !== 16'h0010) begin
            tests_failed++; $display("FAIL init_write_ignored got=%h exp=0010", a_rdata);
        end
        cycle(0, 0, '0, '0, 0, '0);
        tests_run++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 16'h0010) begin
            tests_failed++;
            $display("FAIL rvalid_pulse_hold got=%b%b/%h exp=00/0010", a_rvalid, b_rvalid, a_rdata);
        end
        last_a = 16'h0010;
        last_b = 16'h03FF;
    endtask

    task automatic test_rdw();
        logic [DATA_W-1:0] exp_b;
        exp_b = (RDW_MODE == 1) ? 16'h1234 : model_read(10'h020);
        cycle(1, 1, 10'h020, 16'h1234, 1, 10'h020);
        model_mem[10'h020] = 16'h1234;
        tests_run++;
        if (a_rvalid !== 1'b0) begin
            tests_failed++; $display("FAIL write_no_rvalid got=%b exp=0", a_rvalid);
        end
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== exp_b) begin
            tests_failed++; $display("FAIL rdw_b got=%b/%h exp=1/%h", b_rvalid, b_rdata, exp_b);
        end
        cycle(1, 0, 10'h020, '0, 1, 10'h020);
        tests_run++;
        if (a_rdata !== 16'h1234 || b_rdata !== 16'h1234) begin
            tests_failed++; $display("FAIL rdw_readback got=%h/%h exp=1234/1234", a_rdata, b_rdata);
        end
        last_a = 16'h1234;
        last_b = 16'h1234;
    endtask

    task automatic test_back_to_back();
        int good = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, ADDR_W'(i), '0, 0, '0);
            if (a_rvalid === 1'b1 && a_rdata === model_read(ADDR_W'(i)))
                good++;
            else
                $display("FAIL b2b_word_%0d got=%b/%h exp=1/%h", i, a_rvalid, a_rdata,
                         model_read(ADDR_W'(i)));
        end
        tests_run++;
        if (good != 8) begin
            tests_failed++; $display("FAIL back_to_back got=%0d exp=8 good reads", good);
        end
        last_a = model_read(10'd7);
    endtask

    task automatic test_random();
        logic ae, awe, be, exp_av, exp_bv;
        logic [ADDR_W-1:0] aa, ba;
        logic [DATA_W-1:0] awd, exp_ad, exp_bd;
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            ae  = 1'($urandom); awe = 1'($urandom); be = 1'($urandom);
            aa  = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom);
            ba  = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom);
            awd = DATA_W'($urandom);
            exp_av = ae && !awe;
            exp_ad = exp_av ? model_read(aa) : last_a;
            exp_bv = be;
            if (!be)
                exp_bd = last_b;
            else if (RDW_MODE == 1 && ae && awe && aa == ba && int'(aa) < DEPTH)
                exp_bd = awd;
            else
                exp_bd = model_read(ba);
            cycle(ae, awe, aa, awd, be, ba);
            if (ae && awe && int'(aa) < DEPTH)
                model_mem[aa] = awd;
            if (a_rvalid !== exp_av || a_rdata !== exp_ad || a_perr !== 1'b0) begin
                errs++;
                $display("FAIL rand_a[%0d] got=%b/%h/%b exp=%b/%h/0", i, a_rvalid, a_rdata,
                         a_perr, exp_av, exp_ad);
            end
            if (b_rvalid !== exp_bv || b_rdata !== exp_bd || b_perr !== 1'b0) begin
                errs++;
                $display("FAIL rand_b[%0d] got=%b/%h/%b exp=%b/%h/0", i, b_rvalid, b_rdata,
                         b_perr, exp_bv, exp_bd);
            end
            last_a = exp_ad;
            last_b = exp_bd;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++; $display("FAIL random_traffic got=%0d errors exp=0", errs);
        end
    endtask

    task automatic test_parity();
        logic exp_perr;
`ifdef RAM_PARITY_EN
        dut.par_mem[10'h040] = ~dut.par_mem[10'h040];
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        cycle(0, 0, '0, '0, 1, 10'h040);
        tests_run++;
        if (b_rvalid !== 1'b1 || b_perr !== exp_perr || b_rdata !== model_read(10'h040)) begin
            tests_failed++;
            $display("FAIL parity_b got=%b/%b/%h exp=1/%b/%h", b_rvalid, b_perr, b_rdata,
                     exp_perr, model_read(10'h040));
        end
        cycle(1, 1, 10'h040, 16'h00F1, 0, '0);
        model_mem[10'h040] = 16'h00F1;
        cycle(0, 0, '0, '0, 1, 10'h040);
        tests_run++;
        if (b_perr !== 1'b0 || b_rdata !== 16'h00F1) begin
            tests_failed++; $display("FAIL parity_rewrite got=%b/%h exp=0/00f1", b_perr, b_rdata);
        end
    endtask

    task automatic test_reset_mid_init();
        int n_busy, stray, still_busy;
        cycle(1, 0, 10'h3FF, '0, 1, 10'h3FF);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b1 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0 ||
            a_rdata !== '0 || b_rdata !== '0) begin
            tests_failed++;
            $display("FAIL async_reset got=%b%b%b/%h/%h exp=100/0000/0000", busy, a_rvalid,
                     b_rvalid, a_rdata, b_rdata);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        still_busy = 0;
        for (int n = 0; n < 300; n++) begin
            cycle(0, 0, '0, '0, 0, '0);
            if (busy) still_busy++;
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (still_busy != 300 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL mid_init got=%0d/%b exp=300/1", still_busy, busy);
        end
        run_init(n_busy, stray);
        model_init();
        tests_run++;
        if (n_busy != DEPTH || stray != 0) begin
            tests_failed++;
            $display("FAIL reinit_cycles got=%0d/%0d exp=%0d/0", n_busy, stray, DEPTH);
        end
        cycle(1, 0, 10'h020, '0, 1, 10'h2AB);
        tests_run++;
        if (a_rdata !== 16'h0020 || b_rdata !== 16'h02AB) begin
            tests_failed++; $display("FAIL reinit_contents got=%h/%h exp=0020/02ab", a_rdata, b_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_rdw();
        test_back_to_back();
        test_random();
        test_parity();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
